aes_core: RTL and testbench



---
 rtl/aes_core_pkg.sv | 57 +++++
 rtl/aes_core_sbox.sv | 37 +++
 rtl/aes_core.sv | 172 +++++++++++++++++
 tb/tb_aes_core.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_core_pkg.sv
// Shared types, constants and GF(2^8) arithmetic for the iterative AES-128 core.
package aes_core_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        KEYEXP = 2'd1,
        ROUND  = 2'd2,
        DONE   = 2'd3
    } aes_state_e;

    localparam logic [7:0] RCON_FIRST = 8'h01;
    localparam logic [7:0] RCON_LAST  = 8'h36;
    // x^-1 in GF(2^8): multiplying rcon by it walks the schedule backwards
    localparam logic [7:0] RCON_INV_X = 8'h8D;
    localparam logic [8:0] AES_POLY   = 9'h11B;
    localparam logic [3:0] LAST_ROUND = 4'd10;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        logic [8:0] t;
        t = {a, 1'b0};
        if (t[8]) t = t ^ AES_POLY;
        else      t = t;
        return t[7:0];
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            else      p = p;
            aa = xtime(aa);
        end
        return p;
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24]; a1 = c[23:16]; a2 = c[15:8]; a3 = c[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24]; a1 = c[23:16]; a2 = c[15:8]; a3 = c[7:0];
        return {gmul(a0, 8'h0E) ^ gmul(a1, 8'h0B) ^ gmul(a2, 8'h0D) ^ gmul(a3, 8'h09),
                gmul(a0, 8'h09) ^ gmul(a1, 8'h0E) ^ gmul(a2, 8'h0B) ^ gmul(a3, 8'h0D),
                gmul(a0, 8'h0D) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0E) ^ gmul(a3, 8'h0B),
                gmul(a0, 8'h0B) ^ gmul(a1, 8'h0D) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0E)};
    endfunction

endpackage

// File: rtl/aes_core_sbox.sv
// AES S-box / inverse S-box built from GF(2^8) inversion plus the affine map.
module aes_sbox
    import aes_core_pkg::*;
(
    input  logic [7:0] a,
    input  logic       inv,
    output logic [7:0] y
);

    // a^254 equals a^-1 for nonzero a and maps 0 to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = gmul(x, x);
        acc = sq;
        for (int i = 0; i < 6; i++) begin
            sq  = gmul(sq, sq);
            acc = gmul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] x);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] x);
        return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    endfunction

    // Select forward or inverse substitution
    always_comb begin
        if (inv) y = gf_inv(inv_affine(a));
        else     y = affine(gf_inv(a));
    end

endmodule

// File: rtl/aes_core.sv
// Iterative AES-128 encrypt/decrypt core, one round per clock.
module aes_core
    import aes_core_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic         decrypt_i,
    input  logic [127:0] data_i,
    input  logic [127:0] key_i,
    output logic         ready_o,
    output logic [127:0] data_o
);

    aes_state_e   fsm_r, fsm_next_s;
    logic [3:0]   round_r, round_next_s;
    logic [7:0]   rcon_r, rcon_next_s;
    logic [127:0] key_r, key_next_s;
    logic [127:0] blk_r, blk_next_s;
    logic         dec_r, dec_next_s;
    logic         ready_r, ready_next_s;
    logic [127:0] data_r, data_next_s;

    logic [127:0] sub_bytes_s, shift_s, inv_shift_s, mix_s, inv_mix_s;
    logic [127:0] enc_out_s, dec_ark_s, dec_out_s, next_key_s, prev_key_s;
    logic [31:0]  w0_s, w1_s, w2_s, w3_s, g_in_s, rot_word_s, sub_word_s, f_s;

    genvar gi, gr, gc;

    for (gi = 0; gi < 16; gi++) begin : g_state_sbox
        aes_sbox u_sbox (.a(blk_r[127-8*gi -: 8]), .inv(dec_r), .y(sub_bytes_s[127-8*gi -: 8]));
    end

    // Byte n sits at row n%4, column n/4
    for (gr = 0; gr < 4; gr++) begin : g_row
        for (gc = 0; gc < 4; gc++) begin : g_col
            assign shift_s[127-8*(gr+4*gc) -: 8]     = sub_bytes_s[127-8*(gr+4*((gc+gr)%4)) -: 8];
            assign inv_shift_s[127-8*(gr+4*gc) -: 8] = sub_bytes_s[127-8*(gr+4*((gc+4-gr)%4)) -: 8];
        end
    end

    for (gc = 0; gc < 4; gc++) begin : g_mix
        assign mix_s[127-32*gc -: 32]     = mix_col(shift_s[127-32*gc -: 32]);
        assign inv_mix_s[127-32*gc -: 32] = inv_mix_col(dec_ark_s[127-32*gc -: 32]);
    end

    assign w0_s = key_r[127:96];
    assign w1_s = key_r[95:64];
    assign w2_s = key_r[63:32];
    assign w3_s = key_r[31:0];
    // Stepping backwards, f() is applied to the recovered w[i-1] = w3 ^ w2
    assign g_in_s     = (dec_r && (fsm_r == ROUND)) ? (w3_s ^ w2_s) : w3_s;
    assign rot_word_s = {g_in_s[23:0], g_in_s[31:24]};

    for (gi = 0; gi < 4; gi++) begin : g_key_sbox
        aes_sbox u_sbox (.a(rot_word_s[31-8*gi -: 8]), .inv(1'b0), .y(sub_word_s[31-8*gi -: 8]));
    end

    assign f_s = sub_word_s ^ {rcon_r, 24'h000000};

    // Forward and inverse key schedule steps
    always_comb begin
        next_key_s[127:96] = w0_s ^ f_s;
        next_key_s[95:64]  = w1_s ^ next_key_s[127:96];
        next_key_s[63:32]  = w2_s ^ next_key_s[95:64];
        next_key_s[31:0]   = w3_s ^ next_key_s[63:32];
        prev_key_s         = {w0_s ^ f_s, w1_s ^ w0_s, w2_s ^ w1_s, w3_s ^ w2_s};
    end

    // Round results; the final round skips (Inv)MixColumns
    always_comb begin
        dec_ark_s = inv_shift_s ^ prev_key_s;
        if (round_r == LAST_ROUND) begin
            enc_out_s = shift_s ^ next_key_s;
            dec_out_s = dec_ark_s;
        end else begin
            enc_out_s = mix_s ^ next_key_s;
            dec_out_s = inv_mix_s;
        end
    end

    // Next-state logic; a load overrides everything
    always_comb begin
        fsm_next_s   = fsm_r;
        round_next_s = round_r;
        rcon_next_s  = rcon_r;
        key_next_s   = key_r;
        blk_next_s   = blk_r;
        dec_next_s   = dec_r;
        ready_next_s = ready_r;
        data_next_s  = data_r;
        if (load_i) begin
            dec_next_s   = decrypt_i;
            key_next_s   = key_i;
            rcon_next_s  = RCON_FIRST;
            ready_next_s = 1'b0;
            if (decrypt_i) begin
                blk_next_s   = data_i;
                round_next_s = 4'd0;
                fsm_next_s   = KEYEXP;
            end else begin
                blk_next_s   = data_i ^ key_i;
                round_next_s = 4'd1;
                fsm_next_s   = ROUND;
            end
        end else begin
            case (fsm_r)
                IDLE: fsm_next_s = IDLE;
                KEYEXP: begin
                    if (round_r == LAST_ROUND) begin
                        blk_next_s   = blk_r ^ key_r;
                        rcon_next_s  = RCON_LAST;
                        round_next_s = 4'd1;
                        fsm_next_s   = ROUND;
                    end else begin
                        key_next_s   = next_key_s;
                        rcon_next_s  = xtime(rcon_r);
                        round_next_s = round_r + 4'd1;
                    end
                end
                ROUND: begin
                    if (dec_r) begin
                        key_next_s  = prev_key_s;
                        rcon_next_s = gmul(rcon_r, RCON_INV_X);
                        blk_next_s  = dec_out_s;
                    end else begin
                        key_next_s  = next_key_s;
                        rcon_next_s = xtime(rcon_r);
                        blk_next_s  = enc_out_s;
                    end
                    if (round_r == LAST_ROUND) begin
                        data_next_s  = dec_r ? dec_out_s : enc_out_s;
                        ready_next_s = 1'b1;
                        round_next_s = 4'd0;
                        fsm_next_s   = DONE;
                    end else begin
                        round_next_s = round_r + 4'd1;
                    end
                end
                DONE:    fsm_next_s = DONE;
                default: fsm_next_s = IDLE;
            endcase
        end
    end

    // State registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm_r   <= IDLE;
            round_r <= 4'd0;
            rcon_r  <= 8'h00;
            key_r   <= 128'd0;
            blk_r   <= 128'd0;
            dec_r   <= 1'b0;
            ready_r <= 1'b0;
            data_r  <= 128'd0;
        end else begin
            fsm_r   <= fsm_next_s;
            round_r <= round_next_s;
            rcon_r  <= rcon_next_s;
            key_r   <= key_next_s;
            blk_r   <= blk_next_s;
            dec_r   <= dec_next_s;
            ready_r <= ready_next_s;
            data_r  <= data_next_s;
        end
    end

    assign ready_o = ready_r;
    assign data_o  = data_r;

endmodule

// File: tb/tb_aes_core.sv
// Scoreboard bench for aes_core: known-answer vectors, abort/reset/hold cases, random traffic vs a table-based AES model.
module tb_aes_core;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         load_i = 1'b0;
    logic         decrypt_i = 1'b0;
    logic [127:0] data_i = 128'd0;
    logic [127:0] key_i = 128'd0;
    logic         ready_o;
    logic [127:0] data_o;

    always #5 clk = ~clk;

    aes_core dut (
        .clk(clk), .reset(reset), .load_i(load_i), .decrypt_i(decrypt_i),
        .data_i(data_i), .key_i(key_i), .ready_o(ready_o), .data_o(data_o)
    );

    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PB  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CB  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KB10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [127:0] data;
        int           due;
        string        name;
    } exp_t;
    exp_t sbq[$];

    logic [7:0] sbox_t [256];
    logic [7:0] isbox_t [256];

    function automatic logic [7:0] m_xt(input logic [7:0] a);
        logic [7:0] r;
        r = {a[6:0], 1'b0};
        if (a[7]) r = r ^ 8'h1b;
        return r;
    endfunction

    function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa;
        p = 8'h00; aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = m_xt(aa);
        end
        return p;
    endfunction

    // S-box tables from exp/log tables over generator 0x03
    task automatic init_tables();
        logic [7:0] ex [255];
        int         lg [256];
        logic [7:0] x, inv, s, c;
        x = 8'h01;
        c = 8'h63;
        for (int i = 0; i < 255; i++) begin
            ex[i] = x;
            lg[x] = i;
            x = x ^ m_xt(x);
        end
        for (int a = 0; a < 256; a++) begin
            inv = (a == 0) ? 8'h00 : ex[(255 - lg[a]) % 255];
            for (int b = 0; b < 8; b++)
                s[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8] ^ inv[(b+6)%8] ^ inv[(b+7)%8] ^ c[b];
            sbox_t[a] = s;
            isbox_t[s] = a[7:0];
        end
    endtask

    function automatic logic [127:0] model_aes(input logic [127:0] key, input logic [127:0] din, input bit dec);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [31:0]  tmp;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox_t[tmp[31:24]], sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]]} ^ {rc, 24'h0};
                rc = m_xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = din[127-8*i -: 8];
        if (!dec) begin
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[i/4][31-8*(i%4) -: 8];
            for (int r = 1; r <= 10; r++) begin
                for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
                for (int row = 0; row < 4; row++)
                    for (int col = 0; col < 4; col++)
                        t[row+4*col] = s[row+4*((col+row)%4)];
                for (int col = 0; col < 4; col++) begin
                    a0 = t[4*col]; a1 = t[4*col+1]; a2 = t[4*col+2]; a3 = t[4*col+3];
                    if (r < 10) begin
                        s[4*col]   = m_mul(a0,8'h02) ^ m_mul(a1,8'h03) ^ a2 ^ a3;
                        s[4*col+1] = a0 ^ m_mul(a1,8'h02) ^ m_mul(a2,8'h03) ^ a3;
                        s[4*col+2] = a0 ^ a1 ^ m_mul(a2,8'h02) ^ m_mul(a3,8'h03);
                        s[4*col+3] = m_mul(a0,8'h03) ^ a1 ^ a2 ^ m_mul(a3,8'h02);
                    end else begin
                        s[4*col] = a0; s[4*col+1] = a1; s[4*col+2] = a2; s[4*col+3] = a3;
                    end
                end
                for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
            end
        end else begin
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[40 + i/4][31-8*(i%4) -: 8];
            for (int r = 9; r >= 0; r--) begin
                for (int row = 0; row < 4; row++)
                    for (int col = 0; col < 4; col++)
                        t[row+4*col] = s[row+4*((col+4-row)%4)];
                for (int i = 0; i < 16; i++) s[i] = isbox_t[t[i]] ^ w[4*r + i/4][31-8*(i%4) -: 8];
                if (r > 0) begin
                    for (int col = 0; col < 4; col++) begin
                        a0 = s[4*col]; a1 = s[4*col+1]; a2 = s[4*col+2]; a3 = s[4*col+3];
                        s[4*col]   = m_mul(a0,8'h0e) ^ m_mul(a1,8'h0b) ^ m_mul(a2,8'h0d) ^ m_mul(a3,8'h09);
                        s[4*col+1] = m_mul(a0,8'h09) ^ m_mul(a1,8'h0e) ^ m_mul(a2,8'h0b) ^ m_mul(a3,8'h0d);
                        s[4*col+2] = m_mul(a0,8'h0d) ^ m_mul(a1,8'h09) ^ m_mul(a2,8'h0e) ^ m_mul(a3,8'h0b);
                        s[4*col+3] = m_mul(a0,8'h0b) ^ m_mul(a1,8'h0d) ^ m_mul(a2,8'h09) ^ m_mul(a3,8'h0e);
                    end
                end
            end
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // Monitor: every rising ready_o must match the oldest expected result
    bit   prev_ready = 1'b0;
    exp_t e;
    always @(negedge clk) begin
        if (ready_o && !prev_ready) begin
            if (sbq.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_ready: ready_o rose at cycle %0d data %h, required no result", cyc, data_o);
            end else begin
                e = sbq.pop_front();
                tests++;
                if (data_o !== e.data) begin
                    fails++;
                    $display("FAIL %s data: got %h, required %h", e.name, data_o, e.data);
                end
                tests++;
                if (cyc != e.due) begin
                    fails++;
                    $display("FAIL %s latency: ready at cycle %0d, required %0d", e.name, cyc, e.due);
                end
            end
        end
        prev_ready = ready_o;
    end

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    task automatic start_op(input logic [127:0] k, input logic [127:0] d, input bit dec,
                            input bit expect_res, input logic [127:0] exp_data, input string name);
        @(negedge clk);
        key_i = k; data_i = d; decrypt_i = dec; load_i = 1'b1;
        if (expect_res) sbq.push_back('{exp_data, cyc + 1 + (dec ? 21 : 10), name});
        @(negedge clk);
        load_i = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (sbq.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            tests++; fails++;
            $display("FAIL timeout: %0d results outstanding after %0d cycles, required 0", sbq.size(), budget);
            sbq.delete();
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] rk, rd;
        bit           rdec;
        init_tables();
        repeat (3) @(negedge clk);
        check("reset_ready", {127'd0, ready_o}, 128'd0);
        check("reset_data", data_o, 128'd0);
        reset = 1'b1;
        @(negedge clk);

        start_op(K1, P1, 1'b0, 1'b1, C1, "c1_enc");
        wait_idle(40);
        start_op(K1, C1, 1'b1, 1'b1, P1, "c1_dec");
        wait_idle(40);
        start_op(KB, PB, 1'b0, 1'b1, CB, "appb_enc");
        wait_idle(40);
        check("appb_k10", dut.key_r, KB10);

        // Hold: inputs wiggle without a load
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            decrypt_i = 1'($urandom);
            data_i = {$urandom, $urandom, $urandom, $urandom};
            key_i = {$urandom, $urandom, $urandom, $urandom};
            check("hold_ready", {127'd0, ready_o}, 128'd1);
            check("hold_data", data_o, CB);
        end

        // Abort: second load five cycles after the first
        start_op(KB, PB, 1'b0, 1'b0, 128'd0, "aborted");
        repeat (3) @(negedge clk);
        start_op(K1, P1, 1'b0, 1'b1, C1, "abort_c1");
        check("busy_ready", {127'd0, ready_o}, 128'd0);
        check("busy_data_kept", data_o, CB);
        wait_idle(40);

        // Load on the completion edge restarts
        start_op(KB, PB, 1'b0, 1'b0, 128'd0, "collide_first");
        repeat (8) @(negedge clk);
        start_op(KB, CB, 1'b1, 1'b1, PB, "collide_dec");
        wait_idle(40);

        // Asynchronous reset during round 6
        start_op(K1, P1, 1'b0, 1'b0, 128'd0, "reset_victim");
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("midreset_ready", {127'd0, ready_o}, 128'd0);
        check("midreset_data", data_o, 128'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (25) @(negedge clk);
        check("post_reset_idle", {127'd0, ready_o}, 128'd0);
        start_op(K1, P1, 1'b0, 1'b1, C1, "post_reset_c1");
        wait_idle(40);

        for (int i = 0; i < 24; i++) begin
            rk = {$urandom, $urandom, $urandom, $urandom};
            rd = {$urandom, $urandom, $urandom, $urandom};
            rdec = 1'($urandom);
            start_op(rk, rd, rdec, 1'b1, model_aes(rk, rd, rdec), rdec ? "rand_dec" : "rand_enc");
            wait_idle(40);
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
